fpu_fma_writeback: RTL and testbench
====================================

# fpu_fma_writeback

Result-side companion of the FPU FMA unit: accepts the unit's unstallable completion stream (valid, result, flags, dest reg) into a small FIFO and drains it to the FP register-file write port under a valid/ready handshake. Issue-side credits guarantee a completing result always has a slot, since the FMA pipeline cannot be stalled. Sticky accrued exception flags (fflags) are accumulated on retirement. Sits between the FMA unit outputs and the FP regfile write arbiter in the EX/WB boundary.

## Interface
- FP_WIDTH_D, 64, result width (single-precision results arrive already NaN-boxed)
- DEPTH, 4, FIFO entries; power of two, ≥2
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_unit_start  in  1  FMA unit accepted an op this cycle (consumes one credit)
- i_unit_valid  in  1  FMA unit result valid this cycle
- i_unit_result  in  FP_WIDTH_D  result data
- i_unit_flags  in  riscv_pkg::fp_flags_t (5)  exception flags of result
- i_unit_dest_reg  in  5  destination FP register
- o_can_issue  out  1  a credit is free; issue logic may start an FMA op
- o_wb_valid  out  1  writeback entry available
- o_wb_data  out  FP_WIDTH_D  writeback data
- o_wb_rd  out  5  writeback destination register
- i_wb_ready  in  1  regfile port accepts entry
- i_fflags_clear  in  1  CSR write clears accrued flags
- o_fflags  out  5  sticky accrued flags
- o_idle  out  1  no op in flight and FIFO empty (fence/CSR-read safe)
- o_overflow  out  1  sticky: result arrived with FIFO full, or start with no credit

## Operation
- FIFO: circular buffer, rd/wr pointers of clog2(DEPTH) bits wrapping modulo DEPTH, count of clog2(DEPTH+1) bits.
- Push when i_unit_valid; pop when o_wb_valid & i_wb_ready. Push and pop same cycle: count unchanged, both pointers advance; legal when full.
- Inflight counter (clog2(DEPTH+1) bits): +1 on i_unit_start, −1 on i_unit_valid, unchanged when both.
- o_can_issue = (count + inflight) < DEPTH, from registered state only (same-cycle pop not credited; conservative).
- o_wb_valid = count != 0; o_wb_data/o_wb_rd = head entry, held stable while o_wb_valid & ~i_wb_ready.
- Flags accrue on pop: o_fflags <= (i_fflags_clear ? 0 : o_fflags) | (pop ? head.flags : 0). Clear coincident with pop keeps the popped entry's flags.
- o_idle = (count == 0) & (inflight == 0).
- o_overflow set on push with count==DEPTH and no pop, or i_unit_start with o_can_issue low; offending push is dropped; cleared only by reset.
- Reset (any time, including mid-drain): count, inflight, pointers, o_fflags, o_overflow → 0; o_wb_valid 0, o_wb_data 0, o_wb_rd 0, o_can_issue 1, o_idle 1.

## Timing
- Result at cycle N (FIFO empty, no bypass) → o_wb_valid at N+1.
- Pop at cycle N → head advances at N+1; back-to-back pops sustain 1 entry/cycle.
- o_fflags reflects a pop at cycle N from N+1.
- o_can_issue reflects start at N and pop at N from N+1.

## Configuration
- FPU_WB_BYPASS_EN defined: when count==0 and i_unit_valid, o_wb_valid/o_wb_data/o_wb_rd are driven combinationally from the unit inputs; if i_wb_ready that cycle the entry is not pushed (zero-cycle latency) and its flags accrue; otherwise it is pushed normally.
- Not defined: every result passes through the FIFO; minimum latency 1 cycle; no combinational path from unit inputs to wb outputs.

## Test plan
- Single op: start at cycle 0, valid at 4 with result 0x3FF0000000000000, rd=5, flags NX, ready=1 -> o_wb_valid at 5 with that data/rd; o_fflags=0x01 at 6; o_idle=1 at 6.
- Credit exhaustion: DEPTH=4, 4 starts, ready=0 -> o_can_issue=0 after 4th start; returns 1 one cycle after first pop.
- Full with simultaneous push/pop: FIFO full, ready=1 and unit valid same cycle -> no overflow, count stays 4, order preserved (rd 1,2,3,4,5).
- Flag clear coincident with pop of OF-flagged entry, o_fflags=NV -> o_fflags=OF next cycle.
- Protocol violation: start with o_can_issue=0 -> o_overflow=1, sticky until i_rst_n low.
- Async reset asserted mid-drain with 3 entries -> all outputs at reset values immediately; no writeback after release; with FPU_WB_BYPASS_EN, empty-FIFO result with ready=1 appears on o_wb_valid same cycle.

Source files
------------

// File: rtl/fpu_fma_writeback.sv
// FMA result writeback: credit-protected FIFO from the unstallable FMA completion stream to the
// FP regfile write port, with sticky fflags accrual. Define FPU_WB_BYPASS_EN for zero-latency bypass.
module fpu_fma_writeback #(
    parameter int unsigned FP_WIDTH_D = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_unit_start,
    input  logic                  i_unit_valid,
    input  logic [FP_WIDTH_D-1:0] i_unit_result,
    input  logic [4:0]            i_unit_flags,
    input  logic [4:0]            i_unit_dest_reg,
    output logic                  o_can_issue,
    output logic                  o_wb_valid,
    output logic [FP_WIDTH_D-1:0] o_wb_data,
    output logic [4:0]            o_wb_rd,
    input  logic                  i_wb_ready,
    input  logic                  i_fflags_clear,
    output logic [4:0]            o_fflags,
    output logic                  o_idle,
    output logic                  o_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] INFLIGHT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [FP_WIDTH_D-1:0] data_mem  [DEPTH];
    logic [4:0]            rd_mem    [DEPTH];
    logic [4:0]            flags_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             overflow_q, overflow_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             wb_valid;
    logic             pop;
    logic             fifo_pop;
    logic             bypass_pop;
    logic             push;
    logic             drop;
    logic             can_issue;
    logic [4:0]       pop_flags;
    logic [CNT_W:0]   credit_sum;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);

    // Data/rd are gated by occupancy so a drained or reset FIFO presents zeros.
    always_comb begin
        wb_valid  = ~fifo_empty;
        o_wb_data = fifo_empty ? '0 : data_mem[rd_ptr_q];
        o_wb_rd   = fifo_empty ? '0 : rd_mem[rd_ptr_q];
        pop_flags = flags_mem[rd_ptr_q];
`ifdef FPU_WB_BYPASS_EN
        if (fifo_empty && i_unit_valid) begin
            wb_valid  = 1'b1;
            o_wb_data = i_unit_result;
            o_wb_rd   = i_unit_dest_reg;
            pop_flags = i_unit_flags;
        end
`endif
    end

    assign pop        = wb_valid & i_wb_ready;
    assign fifo_pop   = pop & ~fifo_empty;
    // Only reachable with bypass: the result retires straight from the unit inputs.
    assign bypass_pop = pop & fifo_empty;
    assign push       = i_unit_valid & ~bypass_pop & (~fifo_full | fifo_pop);
    assign drop       = i_unit_valid & fifo_full & ~fifo_pop;

    assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    assign can_issue  = (credit_sum < CREDIT_LIMIT);

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !fifo_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && fifo_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Saturating so a credit violation or a stray valid cannot wrap the counter.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({i_unit_start, i_unit_valid})
            2'b10: if (inflight_q != INFLIGHT_MAX) inflight_d = inflight_q + CNT_W'(1);
            2'b01: if (inflight_q != '0) inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        fflags_d   = (i_fflags_clear ? 5'b0 : fflags_q) | (pop ? pop_flags : 5'b0);
        overflow_d = overflow_q | drop | (i_unit_start & ~can_issue);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            fflags_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            fflags_q   <= fflags_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= i_unit_result;
            rd_mem[wr_ptr_q]    <= i_unit_dest_reg;
            flags_mem[wr_ptr_q] <= i_unit_flags;
        end
    end

    assign o_wb_valid  = wb_valid;
    assign o_can_issue = can_issue;
    assign o_fflags    = fflags_q;
    assign o_idle      = fifo_empty & (inflight_q == '0);
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_fpu_fma_writeback.sv
// Directed bench for fpu_fma_writeback (DEPTH=4); bypass checks follow FPU_WB_BYPASS_EN.
module tb_fpu_fma_writeback;

    logic        clk;
    logic        rst_n;
    logic        unit_start;
    logic        unit_valid;
    logic [63:0] unit_result;
    logic [4:0]  unit_flags;
    logic [4:0]  unit_dest_reg;
    logic        can_issue;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_ready;
    logic        fflags_clear;
    logic [4:0]  fflags;
    logic        idle;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    fpu_fma_writeback #(
        .FP_WIDTH_D(64),
        .DEPTH     (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_unit_start   (unit_start),
        .i_unit_valid   (unit_valid),
        .i_unit_result  (unit_result),
        .i_unit_flags   (unit_flags),
        .i_unit_dest_reg(unit_dest_reg),
        .o_can_issue    (can_issue),
        .o_wb_valid     (wb_valid),
        .o_wb_data      (wb_data),
        .o_wb_rd        (wb_rd),
        .i_wb_ready     (wb_ready),
        .i_fflags_clear (fflags_clear),
        .o_fflags       (fflags),
        .o_idle         (idle),
        .o_overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [4:0] rd, input logic [4:0] fl);
        unit_valid    = 1'b1;
        unit_dest_reg = rd;
        unit_result   = 64'h1000 + 64'(rd);
        unit_flags    = fl;
        tick();
        unit_valid    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; unit_start = 1'b0; unit_valid = 1'b0; unit_result = '0;
        unit_flags = '0; unit_dest_reg = '0; wb_ready = 1'b0; fflags_clear = 1'b0;
        #12;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_can_issue", 64'(can_issue), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_fflags", 64'(fflags), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single op: start at cycle 0, result at cycle 4
        unit_start = 1'b1;
        tick();
        unit_start = 1'b0;
        chk("op_idle_busy", 64'(idle), 64'd0);
        chk("op_can_issue", 64'(can_issue), 64'd1);
        tick(); tick(); tick();
        unit_valid = 1'b1; unit_result = 64'h3FF0000000000000; unit_dest_reg = 5'd5;
        unit_flags = 5'h01; wb_ready = 1'b1;
        #1;
`ifdef FPU_WB_BYPASS_EN
        chk("byp_wb_valid_c4", 64'(wb_valid), 64'd1);
        chk("byp_wb_data_c4", wb_data, 64'h3FF0000000000000);
        chk("byp_wb_rd_c4", 64'(wb_rd), 64'd5);
        tick();
        unit_valid = 1'b0;
        chk("byp_wb_valid_c5", 64'(wb_valid), 64'd0);
        chk("byp_fflags_c5", 64'(fflags), 64'h01);
`else
        chk("op_no_comb_path", 64'(wb_valid), 64'd0);
        tick();
        unit_valid = 1'b0;
        chk("op_wb_valid_c5", 64'(wb_valid), 64'd1);
        chk("op_wb_data_c5", wb_data, 64'h3FF0000000000000);
        chk("op_wb_rd_c5", 64'(wb_rd), 64'd5);
        chk("op_fflags_c5", 64'(fflags), 64'h00);
`endif
        tick();
        chk("op_fflags_c6", 64'(fflags), 64'h01);
        chk("op_idle_c6", 64'(idle), 64'd1);
        chk("op_wb_valid_c6", 64'(wb_valid), 64'd0);
        wb_ready = 1'b0;
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        chk("clear_fflags", 64'(fflags), 64'h00);

        // Credit exhaustion with ready low
        unit_start = 1'b1;
        tick(); tick(); tick();
        chk("credit_3_starts", 64'(can_issue), 64'd1);
        tick();
        unit_start = 1'b0;
        chk("credit_4_starts", 64'(can_issue), 64'd0);
        push_entry(5'd1, 5'h00);
        push_entry(5'd2, 5'h00);
        push_entry(5'd3, 5'h02);
        push_entry(5'd4, 5'h00);
        chk("full_can_issue", 64'(can_issue), 64'd0);
        chk("full_head_rd", 64'(wb_rd), 64'd1);
        chk("full_overflow", 64'(overflow), 64'd0);
        wb_ready = 1'b1;
        #1;
        chk("pop_cycle_can_issue", 64'(can_issue), 64'd0);
        tick();
        wb_ready = 1'b0;
        chk("credit_returned", 64'(can_issue), 64'd1);
        chk("pop_head_rd", 64'(wb_rd), 64'd2);
        unit_start = 1'b1;
        tick();
        unit_start = 1'b0;
        chk("credit_reused", 64'(can_issue), 64'd0);
        push_entry(5'd5, 5'h00);

        // Full FIFO with simultaneous push and pop
        wb_ready = 1'b1;
        unit_valid = 1'b1; unit_dest_reg = 5'd6; unit_result = 64'h1006; unit_flags = 5'h00;
        #1;
        chk("pp_head_rd", 64'(wb_rd), 64'd2);
        tick();
        unit_valid = 1'b0;
        chk("pp_no_overflow", 64'(overflow), 64'd0);
        chk("pp_rd3", 64'(wb_rd), 64'd3);
        chk("pp_data3", wb_data, 64'h1003);
        tick();
        chk("pp_rd4", 64'(wb_rd), 64'd4);
        tick();
        chk("pp_rd5", 64'(wb_rd), 64'd5);
        tick();
        chk("pp_rd6", 64'(wb_rd), 64'd6);
        chk("pp_data6", wb_data, 64'h1006);
        tick();
        chk("pp_drained", 64'(wb_valid), 64'd0);
        chk("pp_fflags_uf", 64'(fflags), 64'h02);
        chk("pp_idle", 64'(idle), 64'd1);
        wb_ready = 1'b0;

        // Clear coincident with pop keeps the popped flags
        fflags_clear = 1'b1;
        tick();
        fflags_clear = 1'b0;
        wb_ready = 1'b1;
        push_entry(5'd7, 5'h10);
        tick(); tick();
        chk("nv_fflags", 64'(fflags), 64'h10);
        wb_ready = 1'b0;
        push_entry(5'd8, 5'h04);
        chk("of_waiting", 64'(wb_valid), 64'd1);
        chk("of_not_yet", 64'(fflags), 64'h10);
        fflags_clear = 1'b1; wb_ready = 1'b1;
        tick();
        fflags_clear = 1'b0; wb_ready = 1'b0;
        chk("clear_pop_fflags", 64'(fflags), 64'h04);
        chk("clear_pop_empty", 64'(wb_valid), 64'd0);

        // Protocol violation: start without credit
        unit_start = 1'b1;
        tick(); tick(); tick(); tick();
        unit_start = 1'b0;
        chk("viol_no_credit", 64'(can_issue), 64'd0);
        chk("viol_pre_overflow", 64'(overflow), 64'd0);
        unit_start = 1'b1;
        tick();
        unit_start = 1'b0;
        chk("viol_overflow", 64'(overflow), 64'd1);
        tick(); tick();
        chk("viol_sticky", 64'(overflow), 64'd1);

        // Async reset mid-drain with 3 entries
        push_entry(5'd9, 5'h01);
        push_entry(5'd10, 5'h01);
        push_entry(5'd11, 5'h01);
        chk("drain_head9", 64'(wb_rd), 64'd9);
        wb_ready = 1'b1;
        tick();
        chk("drain_head10", 64'(wb_rd), 64'd10);
        chk("drain_overflow_kept", 64'(overflow), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", 64'(wb_valid), 64'd0);
        chk("arst_wb_data", wb_data, 64'd0);
        chk("arst_wb_rd", 64'(wb_rd), 64'd0);
        chk("arst_can_issue", 64'(can_issue), 64'd1);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_fflags", 64'(fflags), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_wb_valid1", 64'(wb_valid), 64'd0);
        tick();
        chk("post_rst_wb_valid2", 64'(wb_valid), 64'd0);

        // Empty FIFO, result with ready high
        unit_valid = 1'b1; unit_dest_reg = 5'd12; unit_result = 64'h40; unit_flags = 5'h00;
        #1;
`ifdef FPU_WB_BYPASS_EN
        chk("byp_same_cycle_valid", 64'(wb_valid), 64'd1);
        chk("byp_same_cycle_rd", 64'(wb_rd), 64'd12);
`else
        chk("nobyp_same_cycle_valid", 64'(wb_valid), 64'd0);
`endif
        tick();
        unit_valid = 1'b0;
`ifdef FPU_WB_BYPASS_EN
        chk("byp_not_pushed", 64'(wb_valid), 64'd0);
`else
        chk("nobyp_next_cycle_rd", 64'(wb_rd), 64'd12);
`endif
        wb_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
